prng_period_monitor: RTL
========================

PRNG_PERIOD_MONITOR -- requirements
Module: prng_period_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N, 8, PRNG sample width.
- MAX_CYCLES, 300, sample count at which a run without a repeat is declared timed out.
- CNT_W, 32, width of the period counter.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- load_seed, in, 1, one-cycle pulse that starts a measurement, coincident with the PRNG seed load.
- prng_data, in, N, sample from the upstream PRNG.
- prng_done, in, 1, qualifies prng_data; a sample is accepted only on a cycle where this is 1.
- first_value, out, N, reference sample captured after the start.
- period_count, out, CNT_W, number of RUN samples accepted.
- period_found, out, 1, level; a repeat was detected.
- timeout, out, 1, level; MAX_CYCLES was reached without a repeat.
- busy, out, 1, high in ARM or RUN.
- hist_sel, in, 3, histogram bin select (see REQ-020).
- hist_count, out, 16, selected histogram bin (see REQ-020).

Function
REQ-003 The FSM SHALL have states IDLE, ARM, RUN, FOUND and TIMEOUT.
REQ-004 load_seed=1 in any state SHALL, on that edge:
- clear period_count, first_value, period_found, timeout and the histogram;
- enter ARM.
- The sample presented on that cycle SHALL be ignored.
REQ-005 In ARM, the first accepted sample SHALL be latched into first_value, and the FSM SHALL move to RUN with period_count=0.
REQ-006 In RUN, each accepted sample SHALL increment period_count by 1 on that edge.
REQ-007 Repeat detection in RUN:
- Condition: accepted sample equals first_value and the incremented count is ≥2.
- Action: the FSM SHALL enter FOUND, period_found=1, and period_count SHALL hold the incremented value.
REQ-008 Timeout in RUN:
- Condition: the incremented count equals MAX_CYCLES with no match.
- Action: the FSM SHALL enter TIMEOUT and set timeout=1.
- If a match and the limit occur on the same sample, FOUND SHALL take priority.
REQ-009 Non-accepted cycles (prng_done=0) SHALL change no state, counter or histogram.
REQ-010 FOUND and TIMEOUT SHALL hold all outputs stable until load_seed or reset; IDLE likewise until load_seed.
REQ-011 Output timing and exclusivity:
- Outputs SHALL be registered; each status change is visible the cycle after the deciding sample edge.
- period_found and timeout SHALL never both be 1.
REQ-012 period_count SHALL saturate at all-ones and never wrap.
REQ-013 busy SHALL be 1 exactly in ARM and RUN.

Reset
REQ-014 Asserting reset SHALL immediately (asynchronously) force the following, including in the middle of a measurement:
- FSM to IDLE;
- first_value=0, period_count=0, period_found=0, timeout=0, busy=0;
- all histogram bins to 0.
REQ-015 After reset deasserts, the block SHALL stay in IDLE and ignore prng_data until load_seed.
REQ-016 load_seed asserted while reset=1 SHALL have no effect.

Configuration
REQ-017 The macro PRNG_PERIOD_MONITOR_EXP_HIST_EN SHALL control the exponent histogram.
REQ-018 With the macro defined, the block SHALL keep eight 16-bit bins indexed by the exponent field prng_data[N-2:N-4], the 1-3-(N-4) sign/exponent/mantissa float format.
- Every accepted sample in ARM or RUN SHALL increment its bin, saturating at 0xFFFF.
REQ-019 hist_count SHALL be a combinational read of bin[hist_sel].
REQ-020 With the macro undefined:
- no bin storage SHALL be built;
- hist_sel SHALL be ignored;
- hist_count SHALL be constant 0.
- All other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Constant stream 0x2A, prng_done=1 every cycle, load_seed pulse -> first_value=0x2A, period_found=1, period_count=2, timeout=0.
- Incrementing stream starting at 0x2A, wrapping 0xFF to 0x00 -> period_found=1, period_count=256.
- Stream 0x00 then 0x01 forever, MAX_CYCLES=300 -> timeout=1 with period_count=300, period_found=0.
- prng_done toggling 1/0 on the constant 0x2A stream -> period_count=2 reached only after 3 accepted samples; idle cycles change nothing.
- load_seed pulse at RUN count 50 -> counters cleared, ARM entered, the next sample becomes first_value.
- Reset asserted at RUN count 100 -> all outputs 0 asynchronously.
- With PRNG_PERIOD_MONITOR_EXP_HIST_EN and a stream of 0x35 (exponent 3) on the incrementing scenario -> bin 3 counts per accepted sample, other bins match exponent counts.
- With the macro undefined -> hist_count stays 0.

Source files
------------

// File: rtl/prng_period_monitor.sv
// Measures the repeat period of an upstream PRNG stream relative to the first sample after a seed load.
// Optional exponent histogram is enabled by defining PRNG_PERIOD_MONITOR_EXP_HIST_EN.
module prng_period_monitor #(
    parameter int unsigned N          = 8,
    parameter int unsigned MAX_CYCLES = 300,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_seed,
    input  logic [N-1:0]     prng_data,
    input  logic             prng_done,
    output logic [N-1:0]     first_value,
    output logic [CNT_W-1:0] period_count,
    output logic             period_found,
    output logic             timeout,
    output logic             busy,
    input  logic [2:0]       hist_sel,
    output logic [15:0]      hist_count
);

    localparam int unsigned HIST_BINS = 8;
    localparam int unsigned HIST_W    = 16;
    localparam int unsigned EXP_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_FOUND,
        S_TIMEOUT
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             found_q, found_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             max_hit;
    logic             hist_clr;
    logic             hist_inc;

    // Saturating increment; the limit compare uses the post-increment value
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign max_hit = (cnt_inc == CNT_W'(MAX_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            first_q   <= '0;
            cnt_q     <= '0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            found_q   <= found_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        found_d   = found_q;
        timeout_d = timeout_q;
        hist_clr  = 1'b0;
        hist_inc  = 1'b0;

        if (load_seed) begin
            // The sample coincident with the seed load is deliberately dropped
            state_d   = S_ARM;
            first_d   = '0;
            cnt_d     = '0;
            found_d   = 1'b0;
            timeout_d = 1'b0;
            hist_clr  = 1'b1;
        end else if (prng_done) begin
            case (state_q)
                S_ARM: begin
                    first_d  = prng_data;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                    hist_inc = 1'b1;
                end
                S_RUN: begin
                    cnt_d    = cnt_inc;
                    hist_inc = 1'b1;
                    // A match outranks the limit on the same sample
                    if ((prng_data == first_q) && (cnt_inc >= CNT_W'(2))) begin
                        state_d = S_FOUND;
                        found_d = 1'b1;
                    end else if (max_hit) begin
                        state_d   = S_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == S_ARM) || (state_d == S_RUN);
    end

    assign first_value  = first_q;
    assign period_count = cnt_q;
    assign period_found = found_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

`ifdef PRNG_PERIOD_MONITOR_EXP_HIST_EN
    logic [HIST_W-1:0] bins_q [HIST_BINS];
    logic [EXP_W-1:0]  exp_idx;

    // Exponent field of the 1-3-(N-4) sign/exponent/mantissa format
    assign exp_idx = prng_data[N-2:N-4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < HIST_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (hist_clr) begin
            for (int unsigned i = 0; i < HIST_BINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (hist_inc && (bins_q[exp_idx] != '1)) begin
            bins_q[exp_idx] <= bins_q[exp_idx] + HIST_W'(1);
        end
    end

    assign hist_count = bins_q[hist_sel];
`else
    logic hist_unused;

    assign hist_unused = ^{hist_sel, hist_clr, hist_inc};
    assign hist_count  = '0;
`endif

endmodule
